instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Streams symbolic instructions into instruction memory as 32-bit MIPS words, using only the opcode/funct subset the control unit decodes. It is the encoding counterpart of that decoder.
- Sits between the boot/test sequencer and the instruction-memory write port.
- Accepts one instruction per cycle over a valid/ready handshake.
- Encodes it, writes it at an auto-incrementing address, and stops on END, on a full region, or on an encoding error.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE, 0, first word address written after start.
- DEPTH, 256, maximum words per load session; must satisfy BASE+DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load session.
- in_valid  in  1  the in_* fields hold an instruction.
- in_ready  out  1  block accepts an instruction this cycle.
- in_mnem  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 ADDI, 11 ANDI, 12 J, 13 JAL, 14 END, 15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  26  J-target; I-types use bits [15:0].
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD.
- done  out  1  session ended normally (END or full).
- error  out  1  session aborted on a bad instruction.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset values: all outputs 0, state IDLE, write pointer BASE. Reset is honoured mid-session; no partial write completes after reset asserts.
- States: IDLE, LOAD, DONE, ERROR.
  - IDLE/DONE/ERROR, on start: go to LOAD; pointer=BASE, count=0, done=0, error=0.
  - in_ready = (state==LOAD) && (count<DEPTH). A handshake is in_valid && in_ready.
- Accepted legal instruction (mnem 0-13):
  - The next cycle drives mem_we=1, mem_addr=pointer, mem_wdata=encoded word. This is the only latency (1 cycle).
  - Pointer and count increment in the same cycle as the write.
  - Back-to-back handshakes produce back-to-back writes.
- Encoding, field order op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6]=0 funct[5:0]:
  - R-type: op 000000; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - JR: op 0, rs, rt=rd=0, funct 001000.
  - I-type: op LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100; word = {op, rs, rt, imm[15:0]}.
  - J 000010 and JAL 000011: word = {op, imm[25:0]}.
- END (14) accepted: no write; next state DONE, done=1.
- Illegal mnem 15, or an I-type with in_imm[25:16] != 0:
  - No write.
  - Next state ERROR, error=1, in_ready=0 from the next cycle.
- Full: when count reaches DEPTH after a write, in_ready drops and state goes to DONE the cycle after the last write.
- start while in LOAD is ignored.
- start in the same cycle as the last write: the write completes, then the session restarts.
- done and error are levels, held until the next start or reset.

Decomposition:
- Shared package holds:
  - mnemonic code constants;
  - opcode and funct constants, also used by the control unit, to keep encoder and decoder in lockstep;
  - the state enum.
- One combinational sub-module, instr_encoder (mnem + fields -> 32-bit word + illegal flag). The FSM, pointer and output register live in the top level.

Test Plan:
- start, then ADD rs=1 rt=2 rd=3 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221820; count=1.
- LW rs=29 rt=8 imm=4, then JR rs=31, back-to-back -> 0x8FA80004 @0 and 0x03E00008 @1 on consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF, then J imm=0x10, then END -> 0x1022FFFF @0, 0x08000010 @1; done=1, no third write, in_ready=0.
- ADDI with in_imm=0x10000, or mnem 15 -> no mem_we; error=1 next cycle; in_ready stays 0 until start.
- DEPTH=4, five valid words streamed -> exactly 4 writes at addresses 0-3; in_ready low after the 4th handshake; done=1.
- reset asserted while in_valid is streaming -> outputs 0 immediately (async); after release, a new start writes from address BASE.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode_loader_pkg
// Purpose  : Shared mnemonic codes, MIPS opcode/funct constants and loader
//            state encoding. The control-unit decoder uses the same opcode
//            and funct values, so encoder and decoder cannot drift apart.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encode_loader_pkg;

    // Symbolic instruction codes carried on in_mnem
    localparam logic [3:0] MN_ADD  = 4'd0;
    localparam logic [3:0] MN_SUB  = 4'd1;
    localparam logic [3:0] MN_AND  = 4'd2;
    localparam logic [3:0] MN_OR   = 4'd3;
    localparam logic [3:0] MN_SLT  = 4'd4;
    localparam logic [3:0] MN_JR   = 4'd5;
    localparam logic [3:0] MN_LW   = 4'd6;
    localparam logic [3:0] MN_SW   = 4'd7;
    localparam logic [3:0] MN_BEQ  = 4'd8;
    localparam logic [3:0] MN_BNE  = 4'd9;
    localparam logic [3:0] MN_ADDI = 4'd10;
    localparam logic [3:0] MN_ANDI = 4'd11;
    localparam logic [3:0] MN_J    = 4'd12;
    localparam logic [3:0] MN_JAL  = 4'd13;
    localparam logic [3:0] MN_END  = 4'd14;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Loader states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_ERROR = 2'd3;

endpackage : instr_encode_loader_pkg
`default_nettype wire

// File: rtl/instr_encode_loader_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Combinational mnemonic + register/immediate fields -> 32-bit
//            MIPS word. Flags END separately and reports illegal codes or
//            I-type immediates that do not fit in 16 bits.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encode_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        is_end
);

    // An I-type immediate must be a pure 16-bit value
    logic w_imm_wide;
    assign w_imm_wide = |imm[25:16];

    // Field packing per instruction class
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        is_end  = 1'b0;
        case (mnem)
            MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            MN_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            MN_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            MN_LW:   begin word = {OP_LW,   rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_SW:   begin word = {OP_SW,   rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_BEQ:  begin word = {OP_BEQ,  rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_BNE:  begin word = {OP_BNE,  rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_ADDI: begin word = {OP_ADDI, rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_ANDI: begin word = {OP_ANDI, rs, rt, imm[15:0]}; illegal = w_imm_wide; end
            MN_J:    word = {OP_J,   imm};
            MN_JAL:  word = {OP_JAL, imm};
            MN_END:  is_end = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule : instr_encoder
`default_nettype wire

// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode_loader
// Purpose  : Accepts symbolic instructions over valid/ready, encodes them and
//            writes them to instruction memory at an auto-incrementing word
//            address. A session ends on END, on a full region or on an
//            encoding error.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0,
    parameter int DEPTH  = 256
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_done;
    logic                r_error;

    logic [31:0]         w_word;
    logic                w_illegal;
    logic                w_is_end;
    logic                w_full;
    logic                w_ready;
    logic                w_accept;
    logic                w_start_ok;

    instr_encoder u_encoder (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (w_word),
        .illegal (w_illegal),
        .is_end  (w_is_end)
    );

    assign w_full   = (r_count >= c_depth);
    assign w_ready  = (r_state == ST_LOAD) && !w_full;
    assign w_accept = in_valid && w_ready;
    // A full LOAD session is effectively finished, so a start coinciding
    // with its final write restarts rather than being ignored.
    assign w_start_ok = start && ((r_state != ST_LOAD) || w_full);

    // Session FSM, write pointer, word counter and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_base;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == ST_LOAD) begin
                if (w_accept) begin
                    if (w_illegal) begin
                        r_state <= ST_ERROR;
                        r_error <= 1'b1;
                    end else if (w_is_end) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= w_word;
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_count <= r_count + (ADDR_W+1)'(1);
                    end
                end else if (w_full) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end
            if (w_start_ok) begin
                r_state <= ST_LOAD;
                r_ptr   <= c_base;
                r_count <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign busy      = (r_state == ST_LOAD);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign done      = r_done;
    assign error     = r_error;
    assign count     = r_count;

endmodule : instr_encode_loader
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encode_loader
// Purpose  : Directed self-checking bench for instr_encode_loader with a
//            behavioural session model and hand-computed word checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

    localparam int ADDR_W = 8;
    localparam int BASE   = 0;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_mnem = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
    logic [25:0]       in_imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, error;
    logic [ADDR_W:0]   count;

    instr_encode_loader #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int op_tab [0:13] = '{0, 0, 0, 0, 0, 0, 35, 43, 4, 5, 8, 12, 2, 3};
    int fn_tab [0:5]  = '{32, 34, 36, 37, 42, 8};

    function automatic logic [31:0] ref_word(input int m, input logic [4:0] s, input logic [4:0] t,
                                             input logic [4:0] d, input logic [25:0] im);
        logic [5:0] op;
        logic [5:0] fn;
        op = 6'(op_tab[m]);
        if (m <= 5) begin
            fn = 6'(fn_tab[m]);
            if (m == 5) return {6'd0, s, 15'd0, fn};
            return {6'd0, s, t, d, 5'd0, fn};
        end
        if (m <= 11) return {op, s, t, im[15:0]};
        return {op, im};
    endfunction

    function automatic bit ref_legal(input int m, input logic [25:0] im);
        if (m >= 14) return 1'b0;
        if (m >= 6 && m <= 11 && im[25:16] != 0) return 1'b0;
        return 1'b1;
    endfunction

    bit          m_active, m_done, m_err;
    int          m_n;
    bit          e_we;
    logic [31:0] e_addr, e_data;
    bit          m_rdy, m_can_start;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0; m_done = 0; m_err = 0; m_n = 0; e_we = 0;
        end else begin
            m_rdy = m_active && (m_n < DEPTH);
            m_can_start = start && (!m_active || m_n >= DEPTH);
            e_we = 0;
            if (m_rdy && in_valid) begin
                if (int'(in_mnem) == 14) begin
                    m_active = 0; m_done = 1;
                end else if (!ref_legal(int'(in_mnem), in_imm)) begin
                    m_active = 0; m_err = 1;
                end else begin
                    e_we = 1;
                    e_addr = 32'(BASE + m_n);
                    e_data = ref_word(int'(in_mnem), in_rs, in_rt, in_rd, in_imm);
                    m_n++;
                end
            end else if (m_active && m_n >= DEPTH) begin
                m_active = 0; m_done = 1;
            end
            if (m_can_start) begin
                m_active = 1; m_n = 0; m_done = 0; m_err = 0;
            end
        end
    end

    always @(posedge clk) cyc++;

    typedef struct { logic [31:0] addr; logic [31:0] data; int c; } wr_t;
    wr_t wlog[$];

    // Cycle-by-cycle comparison against the model, plus a log of writes
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_active && (m_n < DEPTH)));
        chk("busy",     32'(busy),     32'(m_active));
        chk("done",     32'(done),     32'(m_done));
        chk("error",    32'(error),    32'(m_err));
        chk("count",    32'(count),    32'(m_n));
        chk("mem_we",   32'(mem_we),   32'(e_we));
        if (e_we) begin
            chk("mem_addr",  32'(mem_addr), e_addr);
            chk("mem_wdata", mem_wdata,     e_data);
        end
        if (mem_we) wlog.push_back('{32'(mem_addr), mem_wdata, cyc});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic put(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [25:0] im);
        in_valid = 1'b1; in_mnem = m; in_rs = s; in_rt = t; in_rd = d; in_imm = im;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_outs", {busy, done, error}, 0);
        @(posedge clk); #1; reset = 1'b0;
        tick();

        // ADD r3 = r1 + r2, then END
        wlog.delete();
        pulse_start();
        put(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        @(negedge clk); #1;
        chk("add_word", mem_wdata, 32'h00221820);
        chk("add_count", 32'(count), 1);
        put(4'd14, 0, 0, 0, 0);
        repeat (2) tick();
        chk("add_nlog", wlog.size(), 1);
        if (wlog.size() >= 1) chk("add_addr", wlog[0].addr, 0);

        // LW then JR back-to-back
        wlog.delete();
        pulse_start();
        put(4'd6, 5'd29, 5'd8, 5'd0, 26'd4);
        put(4'd5, 5'd31, 5'd0, 5'd0, 26'd0);
        put(4'd14, 0, 0, 0, 0);
        repeat (2) tick();
        chk("lwjr_nlog", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("lw_word", wlog[0].data, 32'h8FA80004);
            chk("lw_addr", wlog[0].addr, 0);
            chk("jr_word", wlog[1].data, 32'h03E00008);
            chk("jr_addr", wlog[1].addr, 1);
            chk("b2b_gap", wlog[1].c - wlog[0].c, 1);
        end

        // BEQ, J, END
        wlog.delete();
        pulse_start();
        put(4'd8, 5'd1, 5'd2, 5'd0, 26'h0FFFF);
        put(4'd12, 5'd0, 5'd0, 5'd0, 26'h10);
        put(4'd14, 0, 0, 0, 0);
        repeat (3) tick();
        chk("bj_nlog", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("beq_word", wlog[0].data, 32'h1022FFFF);
            chk("j_word", wlog[1].data, 32'h08000010);
        end
        chk("bj_done", 32'(done), 1);
        chk("bj_ready", 32'(in_ready), 0);

        // Wide I-type immediate aborts
        wlog.delete();
        pulse_start();
        put(4'd10, 5'd1, 5'd1, 5'd0, 26'h10000);
        @(negedge clk); #1;
        chk("addi_err", 32'(error), 1);
        repeat (3) tick();
        chk("addi_ready", 32'(in_ready), 0);
        chk("addi_nlog", wlog.size(), 0);

        // Illegal mnemonic aborts
        pulse_start();
        chk("restart_err", 32'(error), 0);
        put(4'd15, 5'd1, 5'd1, 5'd1, 26'd0);
        repeat (2) tick();
        chk("ill_err", 32'(error), 1);
        chk("ill_nlog", wlog.size(), 0);

        // Five words streamed into a 4-deep region
        wlog.delete();
        pulse_start();
        in_valid = 1'b1; in_mnem = 4'd10;
        for (int i = 0; i < 5; i++) begin
            in_rs = 5'(i); in_rt = 5'(i + 1); in_imm = 26'(i * 16);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("full_nlog", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("full_addr", wlog[i].addr, 32'(i));
        chk("full_done", 32'(done), 1);

        // Start coinciding with the final write restarts the session
        wlog.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) put(4'd3, 5'(i), 5'd2, 5'd7, 26'd0);
        pulse_start();
        put(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        put(4'd14, 0, 0, 0, 0);
        repeat (2) tick();
        chk("rs_nlog", wlog.size(), 5);
        if (wlog.size() == 5) begin
            chk("rs_addr", wlog[4].addr, 0);
            chk("rs_word", wlog[4].data, 32'h00221820);
        end

        // Asynchronous reset mid-stream
        wlog.delete();
        pulse_start();
        in_valid = 1'b1; in_mnem = 4'd1; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
        repeat (2) tick();
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_outs", {busy, done, error, in_ready}, 0);
        chk("arst_wdata", mem_wdata, 0);
        in_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        wlog.delete();
        pulse_start();
        put(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        put(4'd14, 0, 0, 0, 0);
        repeat (2) tick();
        chk("arst_nlog", wlog.size(), 1);
        if (wlog.size() >= 1) chk("arst_addr", wlog[0].addr, BASE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instr_encode_loader
`default_nettype wire
